mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine_if.sv | 29 ++
 rtl/mem_copy_engine.sv | 143 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// Command and bsram port bundle for mem_copy_engine.
// The master modport is the engine's view; slave is the requester/bsram side.
interface mem_copy_engine_if #(
   parameter int WIDTH = 13
);
   logic             start;
   logic             fill;
   logic [WIDTH-1:0] src;
   logic [WIDTH-1:0] dst;
   logic [WIDTH-1:0] len;
   logic [15:0]      fill_value;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] mem_dout_addr;
   logic [15:0]      mem_dout;
   logic             we;
   logic [WIDTH-1:0] mem_din_addr;
   logic [15:0]      mem_din;

   modport master (
      input  start, fill, src, dst, len, fill_value, mem_dout,
      output busy, done, mem_dout_addr, we, mem_din_addr, mem_din
   );

   modport slave (
      output start, fill, src, dst, len, fill_value, mem_dout,
      input  busy, done, mem_dout_addr, we, mem_din_addr, mem_din
   );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / block fill engine for a single-port-per-direction bsram.
// Copy streams one word per cycle: read address leads the write by one cycle.
module mem_copy_engine #(
   parameter int WIDTH = 13,
   parameter int SIZE  = 8192
) (
   input  logic                clk,
   input  logic                reset_n,
   mem_copy_engine_if.master   bus
);
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_COPY  = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_FILL  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam int unsigned      LAST_ADDR_I = SIZE - 1;
   localparam logic [WIDTH-1:0] LAST_ADDR   = LAST_ADDR_I[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

   // Addresses wrap at the top of the bsram.
   function automatic logic [WIDTH-1:0] addr_inc(input logic [WIDTH-1:0] a);
      if (a == LAST_ADDR) begin
         addr_inc = '0;
      end else begin
         addr_inc = a + ONE;
      end
   endfunction

   logic [2:0]       state_r;
   logic [WIDTH-1:0] cnt_r;
   logic [WIDTH-1:0] wptr_r;
   logic             fill_r;
   logic [15:0]      fill_value_r;
   logic             busy_r;
   logic             done_r;
   logic             we_r;
   logic [WIDTH-1:0] rd_addr_r;
   logic [WIDTH-1:0] wr_addr_r;
   logic [15:0]      mem_din_s;

   // Transfer sequencer; cnt_r holds the number of remaining steps after the current one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         wptr_r       <= '0;
         fill_r       <= 1'b0;
         fill_value_r <= 16'h0000;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         we_r         <= 1'b0;
         rd_addr_r    <= '0;
         wr_addr_r    <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  fill_r       <= bus.fill;
                  fill_value_r <= bus.fill_value;
                  wptr_r       <= bus.dst;
                  cnt_r        <= bus.len - ONE;
                  if (bus.len == '0) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else if (bus.fill) begin
                     state_r   <= ST_FILL;
                     busy_r    <= 1'b1;
                     we_r      <= 1'b1;
                     wr_addr_r <= bus.dst;
                  end else begin
                     state_r   <= ST_COPY;
                     busy_r    <= 1'b1;
                     rd_addr_r <= bus.src;
                  end
               end
            end
            ST_COPY: begin
               we_r      <= 1'b1;
               wr_addr_r <= wptr_r;
               wptr_r    <= addr_inc(wptr_r);
               if (cnt_r == '0) begin
                  state_r <= ST_DRAIN;
               end else begin
                  rd_addr_r <= addr_inc(rd_addr_r);
                  cnt_r     <= cnt_r - ONE;
               end
            end
            ST_DRAIN: begin
               we_r    <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
               state_r <= ST_DONE;
            end
            ST_FILL: begin
               if (cnt_r == '0) begin
                  we_r    <= 1'b0;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  wr_addr_r <= addr_inc(wr_addr_r);
                  cnt_r     <= cnt_r - ONE;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               we_r    <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Write data: RAM output passes straight through in copy so the pipeline stays one word per cycle.
   always_comb begin
      mem_din_s = 16'h0000;
      case (state_r)
         ST_COPY, ST_DRAIN, ST_FILL: begin
            if (fill_r) begin
               mem_din_s = fill_value_r;
            end else begin
               mem_din_s = bus.mem_dout;
            end
         end
         default: begin
            mem_din_s = 16'h0000;
         end
      endcase
   end

   assign bus.busy          = busy_r;
   assign bus.done          = done_r;
   assign bus.we            = we_r;
   assign bus.mem_dout_addr = rd_addr_r;
   assign bus.mem_din_addr  = wr_addr_r;
   assign bus.mem_din       = mem_din_s;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a read-before-write bsram model.
module tb_mem_copy_engine;
   localparam int W  = 13;
   localparam int SZ = 8192;

   typedef struct {
      logic        fill;
      int          src;
      int          dst;
      int          len;
      logic [15:0] fval;
      logic        poke;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] ram [0:SZ-1];
   logic [15:0] rd_q = 16'h0000;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          exp_rd_hold = 0;
   vec_t        vecs [6];

   always #5 clk = ~clk;

   mem_copy_engine_if #(.WIDTH(W)) bus ();

   mem_copy_engine #(.WIDTH(W), .SIZE(SZ)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always @(posedge clk) begin
      rd_q <= ram[bus.mem_dout_addr];
      if (bus.we) ram[bus.mem_din_addr] <= bus.mem_din;
   end
   assign bus.mem_dout = rd_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [15:0] snap [$];
      int n;
      int ndone;
      int widx;
      logic e_busy, e_done, e_we;
      n = v.len;
      for (int k = 0; k < n; k++) snap.push_back(ram[(v.src + k) % SZ]);
      ndone = (n == 0) ? 1 : (v.fill ? n + 1 : n + 2);
      @(negedge clk);
      bus.start = 1'b1;
      bus.fill = v.fill;
      bus.src = v.src[W-1:0];
      bus.dst = v.dst[W-1:0];
      bus.len = v.len[W-1:0];
      bus.fill_value = v.fval;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int c = 1; c <= ndone + 2; c++) begin
         e_busy = (n > 0) && (c < ndone);
         e_done = (c == ndone);
         if (v.fill) e_we = (c >= 1) && (c <= n);
         else        e_we = (c >= 2) && (c <= n + 1);
         chk("busy", {31'd0, bus.busy}, {31'd0, e_busy});
         chk("done", {31'd0, bus.done}, {31'd0, e_done});
         chk("we", {31'd0, bus.we}, {31'd0, e_we});
         if (e_we) begin
            widx = v.fill ? c - 1 : c - 2;
            chk("wr_addr", {19'd0, bus.mem_din_addr}, (v.dst + widx) % SZ);
            chk("wr_data", {16'd0, bus.mem_din}, {16'd0, v.fill ? v.fval : snap[widx]});
         end
         if (!v.fill && c <= n) exp_rd_hold = (v.src + c - 1) % SZ;
         chk("rd_addr", {19'd0, bus.mem_dout_addr}, exp_rd_hold);
         if (v.poke && c == 2) begin
            bus.start = 1'b1;
            bus.fill = 1'b1;
            bus.dst = '0;
            bus.len = 13'd5;
         end
         if (v.poke && c == 3) bus.start = 1'b0;
         @(posedge clk);
         #1;
      end
      for (int k = 0; k < n; k++)
         chk("ram", {16'd0, ram[(v.dst + k) % SZ]}, {16'd0, v.fill ? v.fval : snap[k]});
   endtask

   initial begin
      vec_t vr;
      bus.start = 1'b0;
      bus.fill = 1'b0;
      bus.src = '0;
      bus.dst = '0;
      bus.len = '0;
      bus.fill_value = 16'h0000;
      for (int i = 0; i < SZ; i++) ram[i] = 16'(i) ^ 16'h3C00;
      ram[16'h0010] = 16'hAAAA;
      ram[16'h0011] = 16'hBBBB;
      ram[16'h0012] = 16'hCCCC;
      ram[16'h0013] = 16'hDDDD;
      ram[16'h0020] = 16'h0001;
      ram[16'h0021] = 16'h0002;
      ram[16'h0022] = 16'h0003;

      vecs[0] = '{fill: 1'b0, src: 32'h010,  dst: 32'h100,  len: 4, fval: 16'h0000, poke: 1'b0};
      vecs[1] = '{fill: 1'b1, src: 32'h000,  dst: 32'h1FFE, len: 3, fval: 16'hBEEF, poke: 1'b0};
      vecs[2] = '{fill: 1'b0, src: 32'h123,  dst: 32'h456,  len: 0, fval: 16'h0000, poke: 1'b0};
      vecs[3] = '{fill: 1'b0, src: 32'h020,  dst: 32'h021,  len: 3, fval: 16'h0000, poke: 1'b1};
      vecs[4] = '{fill: 1'b0, src: 32'h1FFE, dst: 32'h300,  len: 4, fval: 16'h0000, poke: 1'b0};
      vecs[5] = '{fill: 1'b1, src: 32'h000,  dst: 32'h040,  len: 2, fval: 16'h1234, poke: 1'b0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_we", {31'd0, bus.we}, 32'd0);
      chk("rst_rd_addr", {19'd0, bus.mem_dout_addr}, 32'd0);
      chk("rst_wr_addr", {19'd0, bus.mem_din_addr}, 32'd0);
      chk("rst_din", {16'd0, bus.mem_din}, 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Explicit spot checks of the published examples
      chk("ex_copy_103", {16'd0, ram[16'h0103]}, 32'h0000DDDD);
      chk("ex_fill_000", {16'd0, ram[16'h0000]}, 32'h0000BEEF);
      chk("ex_ovl_23", {16'd0, ram[16'h0023]}, 32'h00000003);
      chk("ex_ovl_poke", {16'd0, ram[16'h0004]}, {16'd0, 16'h0004 ^ 16'h3C00});

      // Reset in cycle 2 of a len=8 copy
      @(negedge clk);
      bus.start = 1'b1;
      bus.fill = 1'b0;
      bus.src = 13'h0200;
      bus.dst = 13'h0400;
      bus.len = 13'd8;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_we", {31'd0, bus.we}, 32'd0);
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
      chk("mid_rst_rd_addr", {19'd0, bus.mem_dout_addr}, 32'd0);
      chk("mid_rst_wr_addr", {19'd0, bus.mem_din_addr}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_hold_done", {31'd0, bus.done}, 32'd0);
         chk("rst_hold_we", {31'd0, bus.we}, 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      chk("rst_no_write", {16'd0, ram[16'h0400]}, {16'd0, 16'h0400 ^ 16'h3C00});
      exp_rd_hold = 0;
      vr = '{fill: 1'b1, src: 32'h000, dst: 32'h777, len: 1, fval: 16'hA5A5, poke: 1'b0};
      run_vec(vr);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("after_rst_idle_we", {31'd0, bus.we}, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
